truth_table_probe: RTL and testbench

Sequential characterizer for 3-input combinational gate modules. It drives all eight input vectors into a device under evaluation (DUE) and waits a programmable settle time on each. It samples the single output and assembles the 8-bit truth-table code that names the gate (e.g. 0xDB), then compares that code against an expected value. It sits on the bench/fabric side of the gate library and reads back the function each gate module implements.

---
 rtl/truth_table_probe_if.sv | 42 ++++
 rtl/truth_table_probe.sv | 101 ++++++++++
 tb/tb_truth_table_probe.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/truth_table_probe_if.sv
// Signal bundle between the truth-table probe and whatever drives it: the
// control/result handshake plus the three DUE inputs and the DUE output.
interface truth_table_probe_if;
    logic       start;
    logic       busy;
    logic       done;
    logic [7:0] table_out;
    logic       match;
    logic [7:0] mismatch;
    logic       in1;
    logic       in2;
    logic       in3;
    logic       dut_out;

    // The probe itself.
    modport slave (
        input  start,
        input  dut_out,
        output busy,
        output done,
        output table_out,
        output match,
        output mismatch,
        output in1,
        output in2,
        output in3
    );

    // The side that requests sweeps and hosts the gate under evaluation.
    modport master (
        output start,
        output dut_out,
        input  busy,
        input  done,
        input  table_out,
        input  match,
        input  mismatch,
        input  in1,
        input  in2,
        input  in3
    );
endinterface

// File: rtl/truth_table_probe.sv
// Sweeps all eight {in1,in2,in3} vectors into a 3-input gate, samples its output
// after SETTLE cycles per vector and reports the 8-bit truth-table code.
module truth_table_probe #(
    parameter int unsigned SETTLE   = 4,
    parameter logic [7:0]  EXPECTED = 8'hDB
) (
    input  logic               clk,
    input  logic               rst,
    truth_table_probe_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        FINISH
    } state_t;

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);

    state_t     state_q,    state_d;
    logic [2:0] index_q,    index_d;
    logic [7:0] settle_q,   settle_d;
    logic [7:0] table_q,    table_d;
    logic       match_q,    match_d;
    logic [7:0] mismatch_q, mismatch_d;

    always_comb begin
        state_d    = state_q;
        index_d    = index_q;
        settle_d   = settle_q;
        table_d    = table_q;
        match_d    = match_q;
        mismatch_d = mismatch_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d    = SWEEP;
                    index_d    = 3'd0;
                    settle_d   = 8'd0;
                    table_d    = 8'h00;
                    match_d    = 1'b0;
                    mismatch_d = 8'h00;
                end
            end

            SWEEP: begin
                if (settle_q == SETTLE_LAST) begin
                    table_d[index_q] = bus.dut_out;
                    settle_d         = 8'd0;
                    index_d          = index_q + 3'd1;
                    // Results are formed from the complete table so they appear with done.
                    if (index_q == 3'd7) begin
                        state_d    = FINISH;
                        match_d    = (table_d == EXPECTED);
                        mismatch_d = table_d ^ EXPECTED;
                    end
                end else begin
                    settle_d = settle_q + 8'd1;
                end
            end

            FINISH: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples
    // the pre-edge values computed above, independent of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            index_q    <= 3'd0;
            settle_q   <= 8'd0;
            table_q    <= 8'h00;
            match_q    <= 1'b0;
            mismatch_q <= 8'h00;
        end else begin
            state_q    <= state_d;
            index_q    <= index_d;
            settle_q   <= settle_d;
            table_q    <= table_d;
            match_q    <= match_d;
            mismatch_q <= mismatch_d;
        end
    end

    // Inputs rest at 000 outside a sweep; busy and done decode straight from state.
    assign {bus.in1, bus.in2, bus.in3} = (state_q == SWEEP) ? index_q : 3'b000;
    assign bus.busy      = (state_q == SWEEP);
    assign bus.done      = (state_q == FINISH);
    assign bus.table_out = table_q;
    assign bus.match     = match_q;
    assign bus.mismatch  = mismatch_q;

endmodule

// File: tb/tb_truth_table_probe.sv
// Directed bench for truth_table_probe: three probes (SETTLE 4, 2, 1) share
// clock, reset and a selectable gate model; a scoreboard holds expected results.
module tb_truth_table_probe;

    typedef struct {
        logic [7:0] tab;
        logic       m;
        logic [7:0] mis;
        int         lat;
    } exp_t;

    localparam int MODE_DB    = 0;
    localparam int MODE_ZERO  = 1;
    localparam int MODE_ONE   = 2;
    localparam int MODE_PIPED = 3;

    logic clk;
    logic rst;
    int   mode;
    int   vectors;
    int   miscompares;
    exp_t sb[$];

    logic       start_a  [3];
    logic       busy_a   [3];
    logic       done_a   [3];
    logic       match_a  [3];
    logic [7:0] tab_a    [3];
    logic [7:0] mis_a    [3];
    logic [2:0] vec_a    [3];
    logic [2:0] pipe_a   [3];

    truth_table_probe_if bus4 ();
    truth_table_probe_if bus2 ();
    truth_table_probe_if bus1 ();

    truth_table_probe #(.SETTLE(4), .EXPECTED(8'hDB)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4));
    truth_table_probe #(.SETTLE(2), .EXPECTED(8'hDB)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));
    truth_table_probe #(.SETTLE(1), .EXPECTED(8'hDB)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference gate 0xDB: output is 0 only for rows 010 and 101.
    function automatic logic gate_db(input logic [2:0] v);
        logic [7:0] g;
        g = 8'hDB;
        return g[v];
    endfunction

    function automatic logic gate_out(input int md, input logic [2:0] v, input logic piped);
        case (md)
            MODE_ZERO:  return 1'b0;
            MODE_ONE:   return 1'b1;
            MODE_PIPED: return piped;
            default:    return gate_db(v);
        endcase
    endfunction

    assign vec_a[0] = {bus4.in1, bus4.in2, bus4.in3};
    assign vec_a[1] = {bus2.in1, bus2.in2, bus2.in3};
    assign vec_a[2] = {bus1.in1, bus1.in2, bus1.in3};

    assign bus4.start   = start_a[0];
    assign bus2.start   = start_a[1];
    assign bus1.start   = start_a[2];
    assign bus4.dut_out = gate_out(mode, vec_a[0], pipe_a[0][2]);
    assign bus2.dut_out = gate_out(mode, vec_a[1], pipe_a[1][2]);
    assign bus1.dut_out = gate_out(mode, vec_a[2], pipe_a[2][2]);

    assign busy_a[0]  = bus4.busy;      assign busy_a[1]  = bus2.busy;      assign busy_a[2]  = bus1.busy;
    assign done_a[0]  = bus4.done;      assign done_a[1]  = bus2.done;      assign done_a[2]  = bus1.done;
    assign match_a[0] = bus4.match;     assign match_a[1] = bus2.match;     assign match_a[2] = bus1.match;
    assign tab_a[0]   = bus4.table_out; assign tab_a[1]   = bus2.table_out; assign tab_a[2]   = bus1.table_out;
    assign mis_a[0]   = bus4.mismatch;  assign mis_a[1]   = bus2.mismatch;  assign mis_a[2]   = bus1.mismatch;

    // Three-stage registered version of the 0xDB gate, one per probe.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) pipe_a[i] <= 3'b000;
            else     pipe_a[i] <= {pipe_a[i][1:0], gate_db(vec_a[i])};
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input int s, input string tag);
        check({tag, "_busy"},     32'(busy_a[s]),  32'd0);
        check({tag, "_done"},     32'(done_a[s]),  32'd0);
        check({tag, "_inputs"},   32'(vec_a[s]),   32'd0);
        check({tag, "_table"},    32'(tab_a[s]),   32'h00);
        check({tag, "_match"},    32'(match_a[s]), 32'd0);
        check({tag, "_mismatch"}, 32'(mis_a[s]),   32'h00);
    endtask

    // Called at a falling edge; returns at the falling edge one cycle after done.
    task automatic do_sweep(input int s, input int settle, input exp_t e,
                            input bit pulse_mid, input bit pulse_done);
        exp_t got;
        int   n;
        bit   in_ok;
        start_a[s] = 1'b1;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        start_a[s] = 1'b0;
        n     = 0;
        in_ok = 1'b1;
        while (!done_a[s] && n < 8 * settle + 16) begin
            if (vec_a[s] !== 3'(n / settle) || busy_a[s] !== 1'b1) in_ok = 1'b0;
            start_a[s] = pulse_mid && (n == 4);
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        start_a[s] = 1'b0;
        got = sb.pop_front();
        check("inputs_step",     32'(in_ok),       32'd1);
        check("done_latency",    32'(n),           32'(got.lat));
        check("table_out",       32'(tab_a[s]),    32'(got.tab));
        check("match",           32'(match_a[s]),  32'(got.m));
        check("mismatch",        32'(mis_a[s]),    32'(got.mis));
        check("busy_at_done",    32'(busy_a[s]),   32'd0);
        check("inputs_at_done",  32'(vec_a[s]),    32'd0);
        start_a[s] = pulse_done;
        @(posedge clk);
        @(negedge clk);
        start_a[s] = 1'b0;
        check("done_one_cycle",  32'(done_a[s]),   32'd0);
        check("restart_dropped", 32'(busy_a[s]),   32'd0);
        check("table_held",      32'(tab_a[s]),    32'(got.tab));
    endtask

    task automatic watch_idle(input int s, input int cycles, input string tag);
        bit seen;
        seen = 1'b0;
        repeat (cycles) begin
            @(negedge clk);
            if (done_a[s] || busy_a[s]) seen = 1'b1;
        end
        check(tag, 32'(seen), 32'd0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        mode        = MODE_DB;
        rst         = 1'b1;
        for (int i = 0; i < 3; i++) start_a[i] = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs(0, "reset4");
        check_reset_outputs(2, "reset1");
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Zero-delay 0xDB gate, SETTLE=4.
        do_sweep(0, 4, '{tab: 8'hDB, m: 1'b1, mis: 8'h00, lat: 32}, 1'b0, 1'b0);

        // Constant-0 and constant-1 gates.
        mode = MODE_ZERO;
        do_sweep(0, 4, '{tab: 8'h00, m: 1'b0, mis: 8'hDB, lat: 32}, 1'b0, 1'b0);
        mode = MODE_ONE;
        do_sweep(0, 4, '{tab: 8'hFF, m: 1'b0, mis: 8'h24, lat: 32}, 1'b0, 1'b0);

        // Three-cycle latency gate: enough settle time at 4, one vector late at 2.
        mode = MODE_PIPED;
        repeat (4) @(negedge clk);
        do_sweep(0, 4, '{tab: 8'hDB, m: 1'b1, mis: 8'h00, lat: 32}, 1'b0, 1'b0);
        do_sweep(1, 2, '{tab: 8'hB7, m: 1'b0, mis: 8'h6C, lat: 16}, 1'b0, 1'b0);

        // Start pulses at T+5 and in the done cycle are dropped; restart right after.
        mode = MODE_DB;
        repeat (2) @(negedge clk);
        do_sweep(0, 4, '{tab: 8'hDB, m: 1'b1, mis: 8'h00, lat: 32}, 1'b1, 1'b1);
        do_sweep(0, 4, '{tab: 8'hDB, m: 1'b1, mis: 8'h00, lat: 32}, 1'b0, 1'b0);
        watch_idle(0, 40, "single_done");

        // Asynchronous reset in the middle of a sweep.
        start_a[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_a[0] = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("partial_table_before_rst", 32'(tab_a[0]), 32'h03);
        rst = 1'b1;
        #1;
        check_reset_outputs(0, "midsweep_rst");
        @(negedge clk);
        rst = 1'b0;
        watch_idle(0, 40, "no_done_after_rst");
        @(negedge clk);
        do_sweep(0, 4, '{tab: 8'hDB, m: 1'b1, mis: 8'h00, lat: 32}, 1'b0, 1'b0);

        // SETTLE=1: a new vector on every edge.
        do_sweep(2, 1, '{tab: 8'hDB, m: 1'b1, mis: 8'h00, lat: 8}, 1'b0, 1'b0);

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "simulation did not finish");
    end

endmodule
